// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states and
// image header geometry.
package inst_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHK,
    S_WAIT,
    S_RUN,
    S_ERR
  } state_e;

  localparam int HDR_LEN = 2;            // word-count header, in bytes
  localparam int LEN_W   = HDR_LEN * 8;  // width of the word-count field

endpackage

// File: rtl/byte_packer.sv
// Assembles four big-endian bytes into a 32-bit word; word_done flags the
// cycle in which the fourth byte is accepted and word is complete.
module byte_packer (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_done
);

  logic [23:0] sr;
  logic [1:0]  lane;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr   <= '0;
      lane <= '0;
    end else if (clr) begin
      sr   <= '0;
      lane <= '0;
    end else if (en) begin
      sr   <= {sr[15:0], byte_data};
      lane <= lane + 2'd1;
    end
  end

  assign word      = {sr, byte_data};
  assign word_done = en && (lane == 2'd3);

endmodule

// File: rtl/inst_loader.sv
// Boot loader: receives a length-prefixed, XOR-checked byte image, writes it
// into instruction memory, then releases the CPU from reset.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int RELEASE_DLY = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rstn,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY) : 1;

  state_e            state, state_nxt;
  logic [7:0]        len_hi;
  logic [ADDR_W-1:0] widx, last_idx;
  logic [7:0]        csum;
  logic [CNT_W-1:0]  dly_cnt;
  logic [LEN_W-1:0]  len_n;
  logic              accept, len_big;
  logic [31:0]       word;
  logic              word_done;

  // A restart request wins over any byte offered in the same cycle.
  assign accept  = byte_valid && byte_ready && !load_start;
  assign len_n   = {len_hi, byte_data};
  assign len_big = 32'(len_n) > (32'd1 << ADDR_W);

  byte_packer u_packer (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (load_start),
    .en        (accept && (state == S_DATA)),
    .byte_data (byte_data),
    .word      (word),
    .word_done (word_done)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block is given a default first, so no latch is inferred.
  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    cpu_rstn   = 1'b0;
    done       = 1'b0;
    error      = 1'b0;

    unique case (state)
      S_LEN_HI, S_LEN_LO, S_DATA, S_CHK: byte_ready = 1'b1;
      S_RUN: begin
        cpu_rstn = 1'b1;
        done     = 1'b1;
      end
      S_ERR:   error = 1'b1;
      default: ;
    endcase

    if (load_start) begin
      state_nxt = S_LEN_HI;
    end else begin
      unique case (state)
        S_LEN_HI: if (accept) state_nxt = S_LEN_LO;
        S_LEN_LO: if (accept) begin
          if (len_n == '0)  state_nxt = S_CHK;
          else if (len_big) state_nxt = S_ERR;
          else              state_nxt = S_DATA;
        end
        S_DATA:   if (word_done && (widx == last_idx)) state_nxt = S_CHK;
        S_CHK:    if (accept) state_nxt = (byte_data == csum) ? S_WAIT : S_ERR;
        S_WAIT:   if (dly_cnt == CNT_W'(RELEASE_DLY - 1)) state_nxt = S_RUN;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      len_hi   <= '0;
      widx     <= '0;
      last_idx <= '0;
      csum     <= '0;
      dly_cnt  <= '0;
    end else begin
      // The write strobe is registered, so a pulse already launched completes
      // even if a restart arrives alongside it.
      im_we <= word_done;
      if (word_done) begin
        im_addr  <= widx;
        im_wdata <= word;
      end
      dly_cnt <= (state == S_WAIT) ? dly_cnt + CNT_W'(1) : '0;

      if (load_start) begin
        widx <= '0;
        csum <= '0;
      end else begin
        if (accept && (state == S_LEN_HI)) len_hi <= byte_data;
        if (accept && (state == S_LEN_LO)) last_idx <= ADDR_W'(len_n - LEN_W'(1));
        if (accept && (state == S_DATA))   csum <= csum ^ byte_data;
        if (word_done)                     widx <= widx + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed scenarios plus randomized
// images checked against a byte-level model of the image format.
module tb_inst_loader;

  localparam int ADDR_W      = 7;
  localparam int RELEASE_DLY = 4;
  localparam int DEPTH       = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rstn;
  logic              load_start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_rstn;
  logic              done;
  logic              error;

  inst_loader #(.ADDR_W(ADDR_W), .RELEASE_DLY(RELEASE_DLY)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .load_start (load_start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .cpu_rstn   (cpu_rstn),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         got_q[$];
  wr_t         exp_q[$];
  logic [7:0]  img[$];
  logic [31:0] fixed_words[$];
  bit          exp_ok;
  int          dbl;
  logic        prev_we = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Write-port monitor.
  always @(negedge clk) begin
    if (im_we) got_q.push_back(wr_t'{addr: im_addr, data: im_wdata});
    if (im_we && prev_we) dbl++;
    prev_we = im_we;
  end

  // Reference model: builds the byte stream and the writes/outcome it implies.
  task automatic make_image(input int n, input bit use_fixed, input int csum_ovr);
    logic [7:0]  x;
    logic [31:0] w;
    img.delete();
    exp_q.delete();
    x = 8'h00;
    img.push_back(8'(n >> 8));
    img.push_back(8'(n));
    if (n > DEPTH) begin
      exp_ok = 1'b0;
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = use_fixed ? fixed_words[i] : $urandom;
      for (int b = 3; b >= 0; b--) begin
        img.push_back(w[8*b +: 8]);
        x ^= w[8*b +: 8];
      end
      exp_q.push_back(wr_t'{addr: ADDR_W'(i), data: w});
    end
    if (csum_ovr < 0) begin
      img.push_back(x);
      exp_ok = 1'b1;
    end else begin
      img.push_back(8'(csum_ovr));
      exp_ok = (8'(csum_ovr) == x);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    byte_data = 8'($urandom);
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
  endtask

  task automatic start_load();
    got_q.delete();
    dbl        = 0;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_image(input int gap_max);
    for (int i = 0; i < img.size(); i++) send_byte(img[i], gap_max);
  endtask

  task automatic finish_load(input string tag);
    int k;
    k = 0;
    while (!(done || error) && k < 60) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_timeout"}, 32'(k < 60), 32'd1);
    check({tag, "_done"},     32'(done),     32'(exp_ok));
    check({tag, "_error"},    32'(error),    32'(!exp_ok));
    check({tag, "_cpu_rstn"}, 32'(cpu_rstn), 32'(exp_ok));
    check({tag, "_nwrites"},  32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_wr%0d_addr", tag, i), 32'(got_q[i].addr), 32'(exp_q[i].addr));
      check($sformatf("%s_wr%0d_data", tag, i), got_q[i].data, exp_q[i].data);
    end
    check({tag, "_we_single"}, 32'(dbl), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_im_we"},      32'(im_we),      32'd0);
    check({tag, "_im_addr"},    32'(im_addr),    32'd0);
    check({tag, "_im_wdata"},   im_wdata,        32'd0);
    check({tag, "_cpu_rstn"},   32'(cpu_rstn),   32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_error"},      32'(error),      32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, r, ovr;
    rstn       = 1'b0;
    load_start = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_hold_ready", 32'(byte_ready), 32'd0);
    check("idle_hold_cpu",   32'(cpu_rstn),   32'd0);

    // Two-word image; the XOR of its eight data bytes is 0x0E.
    fixed_words = '{32'h20080005, 32'h2009000A};
    make_image(2, 1'b1, -1);
    start_load();
    send_image(2);
    for (int k = 0; k <= RELEASE_DLY; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("release_dly_%0d", k), 32'(done), 32'(k == RELEASE_DLY));
    end
    finish_load("two_words");

    make_image(2, 1'b1, 0);
    start_load();
    send_image(2);
    finish_load("bad_csum");

    make_image(DEPTH + 1, 1'b0, -1);
    start_load();
    send_image(1);
    check("too_long_error", 32'(error),      32'd1);
    check("too_long_ready", 32'(byte_ready), 32'd0);
    finish_load("too_long");

    make_image(0, 1'b0, -1);
    start_load();
    send_image(2);
    finish_load("empty");

    // Restart from RUN with a byte offered in the same cycle: the byte must be dropped.
    got_q.delete();
    dbl        = 0;
    load_start = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'h7F;
    @(negedge clk);
    load_start = 1'b0;
    byte_valid = 1'b0;
    check("restart_cpu_rstn", 32'(cpu_rstn),   32'd0);
    check("restart_done",     32'(done),       32'd0);
    check("restart_ready",    32'(byte_ready), 32'd1);
    make_image(3, 1'b0, -1);
    send_image(2);
    finish_load("after_restart");

    // Asynchronous reset in the middle of word 1.
    make_image(3, 1'b0, -1);
    start_load();
    for (int i = 0; i < 8; i++) send_byte(img[i], 1);
    byte_valid = 1'b1;
    byte_data  = img[8];
    #2 rstn = 1'b0;
    #1 check_reset_outputs("mid_reset");
    @(negedge clk);
    rstn       = 1'b1;
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("post_reset_idle", 32'(byte_ready), 32'd0);
    make_image(2, 1'b0, -1);
    start_load();
    send_image(2);
    finish_load("post_reset");

    for (int it = 0; it < 10; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      n = DEPTH;
      else if (r == 1) n = DEPTH + 1 + $urandom_range(0, 1000);
      else             n = $urandom_range(0, 6);
      ovr = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 255) : -1;
      make_image(n, 1'b0, ovr);
      start_load();
      send_image($urandom_range(0, 3));
      finish_load($sformatf("rand%0d_n%0d", it, n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
